multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM that sequences the shared datapath (PC, Registers, ALU, ALU_Control, single-port memory) as a multicycle RV32 subset: R-type, I-type ALU, LW, SW, BEQ.
- Replaces the single-cycle Control block.
- Owns the memory request handshake, including the wait timeout, and the illegal-opcode trap.
- Keeps a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles with mem_ready_i low in a memory state before trapping. A value of 0 disables the timeout.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous reset, active-high.
- start_i  input  1  run enable, level-sensitive.
- opcode_i  input  7  opcode field from the IR (inst[6:0]).
- zero_i  input  1  ALU Zero output.
- mem_ready_i  input  1  memory completion; one pulse completes one access.
- mem_req_o  output  1  memory access request.
- mem_we_o  output  1  memory write (store).
- iord_o  output  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write_o  output  1  IR load enable.
- pc_write_o  output  1  PC load enable.
- pc_src_o  output  1  PC source select: 0 = ALU result, 1 = ALUOut (branch target).
- reg_write_o  output  1  register file write enable.
- wb_sel_o  output  2  write-back source: 00 = ALUOut, 01 = MDR.
- alu_src_a_o  output  2  ALU A select: 00 = PC, 01 = rs1.
- alu_src_b_o  output  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op_o  output  2  ALU op class: 00 = add, 01 = sub, 10 = R-funct, 11 = I-funct.
- state_o  output  4  current state encoding.
- busy_o  output  1  high whenever the state is not IDLE or TRAP.
- illegal_o  output  1  high in TRAP after an illegal opcode.
- timeout_o  output  1  high in TRAP after a memory timeout.
- retired_o  output  CNT_W  count of retired instructions.

Behaviour:
- State encodings:
  - IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5
  - MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, TRAP=15
- Reset (asynchronous, any time including mid-access):
  - State goes to IDLE.
  - All outputs are 0; retired_o is 0; the wait counter is 0.
- Unlisted outputs are 0 in every state.
- IDLE: if start_i=1, go to FETCH on the next edge.
- FETCH:
  - mem_req_o=1, iord_o=0, alu_src_a_o=00, alu_src_b_o=01, alu_op_o=00.
  - ir_write_o and pc_write_o equal mem_ready_i (Mealy).
  - On ready, go to DECODE; otherwise hold.
- DECODE:
  - alu_src_a_o=00, alu_src_b_o=10, alu_op_o=00; this precomputes the branch target into ALUOut.
  - Next state by opcode_i:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → MEM_ADDR
    - 1100011 → BRANCH
    - any other value → TRAP with illegal_o=1
- EXEC_R: alu_src_a_o=01, alu_src_b_o=00, alu_op_o=10; go to WB_ALU.
- EXEC_I: alu_src_a_o=01, alu_src_b_o=10, alu_op_o=11; go to WB_ALU.
- MEM_ADDR: alu_src_a_o=01, alu_src_b_o=10, alu_op_o=00; go to MEM_RD if opcode_i=0000011, otherwise MEM_WR.
- MEM_RD: mem_req_o=1, iord_o=1; on ready go to WB_MEM.
- MEM_WR: mem_req_o=1, iord_o=1, mem_we_o=1; on ready, retire.
- WB_ALU: reg_write_o=1, wb_sel_o=00; retire.
- WB_MEM: reg_write_o=1, wb_sel_o=01; retire.
- BRANCH:
  - alu_src_a_o=01, alu_src_b_o=00, alu_op_o=01, pc_src_o=1.
  - pc_write_o=zero_i (Mealy).
  - Retire.
- Retire:
  - retired_o increments by 1 on the exiting edge and saturates at all-ones.
  - Next state is FETCH if start_i=1, otherwise IDLE.
  - start_i is sampled only at IDLE and at retire. Deasserting it mid-instruction lets the current instruction complete.
- opcode_i must be stable from DECODE until retire; the IR holds it there.
- Latency with zero memory wait:
  - R-type, I-type, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ: 3 cycles.
  - Each memory wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD and MEM_WR.
  - Increments on each cycle in those states with mem_ready_i=0.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT with ready still low, go to TRAP with timeout_o=1.
  - If ready arrives in the same cycle as the limit, ready wins.
- TRAP:
  - All control outputs are 0, busy_o=0, and the cause flag stays high.
  - The state is left only by reset; start_i is ignored.
- mem_ready_i outside FETCH, MEM_RD and MEM_WR is ignored.

Test Plan:
- Reset check: assert rst_i mid-FETCH with mem_req_o=1 → same cycle, state_o=0, mem_req_o=0, retired_o=0; after release with start_i=0, the block stays in IDLE.
- R-type: start_i=1, opcode 0110011, mem_ready_i=1 constantly → state_o sequence 1,2,3,8,1; reg_write_o=1 only in state 8; retired_o=1 after 4 cycles.
- Loads and stores: LW with mem_ready_i delayed 2 cycles in MEM_RD → 7 cycles total, wb_sel_o=01 with reg_write_o=1 in WB_MEM. SW → mem_we_o=1 only in state 7, reg_write_o is never high.
- BEQ: opcode 1100011 with zero_i=1 → pc_write_o=1 and pc_src_o=1 in state 10. With zero_i=0 → pc_write_o=0. Both take 3 cycles and increment retired_o.
- Illegal opcode: opcode 1111111 → DECODE goes to state 15 with illegal_o=1, busy_o=0, and the block stays there for 20 cycles despite start_i=1.
- Timeout and start_i: MEM_TIMEOUT=15 with mem_ready_i held low in FETCH → after 15 wait cycles, state 15 and timeout_o=1. Separately, dropping start_i during EXEC_R → WB_ALU completes, then IDLE, and retired_o increments.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multicycle controller and its datapath/testbench.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [6:0]       opcode_i;
  logic             zero_i;
  logic             mem_ready_i;
  logic             mem_req_o;
  logic             mem_we_o;
  logic             iord_o;
  logic             ir_write_o;
  logic             pc_write_o;
  logic             pc_src_o;
  logic             reg_write_o;
  logic [1:0]       wb_sel_o;
  logic [1:0]       alu_src_a_o;
  logic [1:0]       alu_src_b_o;
  logic [1:0]       alu_op_o;
  logic [3:0]       state_o;
  logic             busy_o;
  logic             illegal_o;
  logic             timeout_o;
  logic [CNT_W-1:0] retired_o;

  // Datapath / stimulus side
  modport master (
    output start_i, opcode_i, zero_i, mem_ready_i,
    input  mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
           reg_write_o, wb_sel_o, alu_src_a_o, alu_src_b_o, alu_op_o,
           state_o, busy_o, illegal_o, timeout_o, retired_o
  );

  // Controller side
  modport slave (
    input  start_i, opcode_i, zero_i, mem_ready_i,
    output mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
           reg_write_o, wb_sel_o, alu_src_a_o, alu_src_b_o, alu_op_o,
           state_o, busy_o, illegal_o, timeout_o, retired_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32-subset control FSM: sequences fetch/decode/execute/memory/write-back,
// owns the memory handshake with wait timeout, traps illegal opcodes, counts retirements.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  multicycle_ctrl_if.slave   bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_ALU   = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    TRAP     = 4'd15
  } state_t;

  // Moore control outputs, registered from the next state so they align with state_o
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_src;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       busy;
  } ctl_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  // Counter only needs to reach MEM_TIMEOUT-1; the trap fires on the cycle that would make it MEM_TIMEOUT
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic [CNT_W-1:0]  retired;
  ctl_t              ctl;
  logic              illegal;
  logic              timeout;
  logic              retire;
  logic              set_illegal;
  logic              set_timeout;
  logic              mem_state;
  logic              timed_out;

  function automatic ctl_t ctl_for(state_t s);
    ctl_t c;
    c = '0;
    c.busy = (s != IDLE) && (s != TRAP);
    case (s)
      FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = 2'b01; end
      DECODE:   begin c.alu_src_b = 2'b10; end
      EXEC_R:   begin c.alu_src_a = 2'b01; c.alu_op = 2'b10; end
      EXEC_I:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
      MEM_ADDR: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
      MEM_RD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
      MEM_WR:   begin c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = 1'b1; end
      WB_ALU:   begin c.reg_write = 1'b1; end
      WB_MEM:   begin c.reg_write = 1'b1; c.wb_sel = 2'b01; end
      BRANCH:   begin c.alu_src_a = 2'b01; c.alu_op = 2'b01; c.pc_src = 1'b1; end
      default:  c = c;
    endcase
    return c;
  endfunction

  // Next-state, retire and wait-counter decisions
  always_comb begin
    state_next  = state;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    mem_state   = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    timed_out   = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT) && !bus.mem_ready_i;
    case (state)
      IDLE:     if (bus.start_i) state_next = FETCH;
      FETCH:    if (bus.mem_ready_i) state_next = DECODE;
                else if (timed_out) begin state_next = TRAP; set_timeout = 1'b1; end
      DECODE:   case (bus.opcode_i)
                  OP_R:         state_next = EXEC_R;
                  OP_I:         state_next = EXEC_I;
                  OP_LW, OP_SW: state_next = MEM_ADDR;
                  OP_B:         state_next = BRANCH;
                  default:      begin state_next = TRAP; set_illegal = 1'b1; end
                endcase
      EXEC_R,
      EXEC_I:   state_next = WB_ALU;
      MEM_ADDR: state_next = (bus.opcode_i == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (bus.mem_ready_i) state_next = WB_MEM;
                else if (timed_out) begin state_next = TRAP; set_timeout = 1'b1; end
      MEM_WR:   if (bus.mem_ready_i) retire = 1'b1;
                else if (timed_out) begin state_next = TRAP; set_timeout = 1'b1; end
      WB_ALU,
      WB_MEM,
      BRANCH:   retire = 1'b1;
      TRAP:     state_next = TRAP;
      default:  state_next = IDLE;
    endcase
    if (retire) state_next = bus.start_i ? FETCH : IDLE;

    // Entering a memory state restarts the wait count; lingering without ready advances it
    wait_next = wait_cnt;
    if ((state_next != state) &&
        ((state_next == FETCH) || (state_next == MEM_RD) || (state_next == MEM_WR)))
      wait_next = '0;
    else if (mem_state && !bus.mem_ready_i && (MEM_TIMEOUT != 0))
      wait_next = wait_cnt + 1'b1;
  end

  // State, counters, sticky trap causes and registered Moore outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
      retired  <= '0;
      ctl      <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      ctl      <= ctl_for(state_next);
      if (retire && !(&retired)) retired <= retired + 1'b1;
      if (set_illegal) illegal <= 1'b1;
      if (set_timeout) timeout <= 1'b1;
    end
  end

  assign bus.mem_req_o   = ctl.mem_req;
  assign bus.mem_we_o    = ctl.mem_we;
  assign bus.iord_o      = ctl.iord;
  assign bus.pc_src_o    = ctl.pc_src;
  assign bus.reg_write_o = ctl.reg_write;
  assign bus.wb_sel_o    = ctl.wb_sel;
  assign bus.alu_src_a_o = ctl.alu_src_a;
  assign bus.alu_src_b_o = ctl.alu_src_b;
  assign bus.alu_op_o    = ctl.alu_op;
  assign bus.busy_o      = ctl.busy;
  // IR/PC loads follow the memory completion directly; branch PC load follows Zero
  assign bus.ir_write_o  = (state == FETCH) && bus.mem_ready_i;
  assign bus.pc_write_o  = ((state == FETCH) && bus.mem_ready_i) || ((state == BRANCH) && bus.zero_i);
  assign bus.state_o     = state;
  assign bus.illegal_o   = illegal;
  assign bus.timeout_o   = timeout;
  assign bus.retired_o   = retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level trace model expanded into per-cycle vectors.
module tb_multicycle_ctrl;
  localparam int CNT_W       = 16;
  localparam int MEM_TIMEOUT = 15;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_EXEC_I = 4,
                 S_MEM_ADDR = 5, S_MEM_RD = 6, S_MEM_WR = 7, S_WB_ALU = 8,
                 S_WB_MEM = 9, S_BRANCH = 10, S_TRAP = 15;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus();
  multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write;
    logic [1:0] wb_sel, src_a, src_b, alu_op;
    logic       busy, illegal, timeout;
  } outs_t;

  typedef struct {
    logic             start, ready, zero;
    logic [6:0]       opcode;
    logic [3:0]       state;
    outs_t            outs;
    logic [CNT_W-1:0] retired;
  } vec_t;

  vec_t             table_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               vec_no   = 0;
  logic [CNT_W-1:0] rt;
  bit               in_idle, f_ill, f_to;

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [6:0] ropc();
    return 7'($urandom);
  endfunction

  function automatic logic [6:0] opc_of(int kind);
    case (kind)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      default: return 7'b1100011;
    endcase
  endfunction

  // Expected control word for a state, straight from the per-state output rules
  function automatic outs_t exp_out(int s, logic ready, logic zero);
    outs_t o;
    o = '0;
    o.busy = (s != S_IDLE) && (s != S_TRAP);
    case (s)
      S_FETCH:    begin o.mem_req = 1; o.src_b = 2'b01; o.ir_write = ready; o.pc_write = ready; end
      S_DECODE:   o.src_b = 2'b10;
      S_EXEC_R:   begin o.src_a = 2'b01; o.alu_op = 2'b10; end
      S_EXEC_I:   begin o.src_a = 2'b01; o.src_b = 2'b10; o.alu_op = 2'b11; end
      S_MEM_ADDR: begin o.src_a = 2'b01; o.src_b = 2'b10; end
      S_MEM_RD:   begin o.mem_req = 1; o.iord = 1; end
      S_MEM_WR:   begin o.mem_req = 1; o.iord = 1; o.mem_we = 1; end
      S_WB_ALU:   o.reg_write = 1;
      S_WB_MEM:   begin o.reg_write = 1; o.wb_sel = 2'b01; end
      S_BRANCH:   begin o.src_a = 2'b01; o.alu_op = 2'b01; o.pc_src = 1; o.pc_write = zero; end
      S_TRAP:     begin o.illegal = f_ill; o.timeout = f_to; end
      default:    o = o;
    endcase
    return o;
  endfunction

  function automatic outs_t act_outs();
    outs_t o;
    o.mem_req = bus.mem_req_o;     o.mem_we = bus.mem_we_o;     o.iord = bus.iord_o;
    o.ir_write = bus.ir_write_o;   o.pc_write = bus.pc_write_o; o.pc_src = bus.pc_src_o;
    o.reg_write = bus.reg_write_o; o.wb_sel = bus.wb_sel_o;     o.src_a = bus.alu_src_a_o;
    o.src_b = bus.alu_src_b_o;     o.alu_op = bus.alu_op_o;     o.busy = bus.busy_o;
    o.illegal = bus.illegal_o;     o.timeout = bus.timeout_o;
    return o;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %h, expected %h", name, vec_no, act, exp);
    end
  endtask

  task automatic push(int s, logic start, logic ready, logic zero, logic [6:0] opc);
    vec_t v;
    v.start = start; v.ready = ready; v.zero = zero; v.opcode = opc;
    v.state = 4'(s); v.outs = exp_out(s, ready, zero); v.retired = rt;
    table_q.push_back(v);
  endtask

  task automatic retire(int s, logic ready, logic zero, logic [6:0] opc, logic cont);
    push(s, cont, ready, zero, opc);
    if (rt != '1) rt = rt + 1'b1;
    in_idle = !cont;
  endtask

  // One instruction: fw fetch wait cycles, mw data wait cycles; cont = start_i at retire
  task automatic push_instr(int kind, int fw, int mw, logic z, logic cont);
    logic [6:0] opc;
    opc = opc_of(kind);
    if (in_idle) begin
      for (int k = 0; k < int'($urandom_range(2, 0)); k++) push(S_IDLE, 0, rbit(), rbit(), ropc());
      push(S_IDLE, 1, rbit(), rbit(), ropc());
    end
    for (int w = 0; w < fw; w++) push(S_FETCH, rbit(), 0, rbit(), ropc());
    push(S_FETCH, rbit(), 1, rbit(), ropc());
    push(S_DECODE, rbit(), rbit(), rbit(), opc);
    case (kind)
      K_R: begin
        push(S_EXEC_R, rbit(), rbit(), rbit(), opc);
        retire(S_WB_ALU, rbit(), rbit(), opc, cont);
      end
      K_I: begin
        push(S_EXEC_I, rbit(), rbit(), rbit(), opc);
        retire(S_WB_ALU, rbit(), rbit(), opc, cont);
      end
      K_LW: begin
        push(S_MEM_ADDR, rbit(), rbit(), rbit(), opc);
        for (int w = 0; w < mw; w++) push(S_MEM_RD, rbit(), 0, rbit(), opc);
        push(S_MEM_RD, rbit(), 1, rbit(), opc);
        retire(S_WB_MEM, rbit(), rbit(), opc, cont);
      end
      K_SW: begin
        push(S_MEM_ADDR, rbit(), rbit(), rbit(), opc);
        for (int w = 0; w < mw; w++) push(S_MEM_WR, rbit(), 0, rbit(), opc);
        retire(S_MEM_WR, 1, rbit(), opc, cont);
      end
      default: retire(S_BRANCH, rbit(), z, opc, cont);
    endcase
  endtask

  task automatic run_table(string label);
    vec_t v;
    for (int i = 0; i < table_q.size(); i++) begin
      v = table_q[i];
      @(negedge clk);
      bus.start_i = v.start; bus.mem_ready_i = v.ready;
      bus.zero_i = v.zero;   bus.opcode_i = v.opcode;
      #1;
      check({label, " state"},   32'(bus.state_o),   32'(v.state));
      check({label, " outs"},    32'(act_outs()),    32'(v.outs));
      check({label, " retired"}, 32'(bus.retired_o), 32'(v.retired));
      $display("%s vec %0d: st=%0d rdy=%0b start=%0b ret=%0d", label, vec_no,
               bus.state_o, v.ready, v.start, bus.retired_o);
      vec_no++;
    end
    table_q.delete();
  endtask

  task automatic model_reset();
    rt = '0; in_idle = 1; f_ill = 0; f_to = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    bus.start_i = 0; bus.mem_ready_i = 0; bus.zero_i = 0; bus.opcode_i = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  initial begin
    bus.start_i = 0; bus.mem_ready_i = 0; bus.zero_i = 0; bus.opcode_i = '0;
    model_reset();
    #1;
    check("reset state",   32'(bus.state_o),   32'(S_IDLE));
    check("reset outs",    32'(act_outs()),    32'(0));
    check("reset retired", 32'(bus.retired_o), 32'(0));
    do_reset();

    // Directed instructions, including the ready-on-limit boundary
    push_instr(K_R,  0, 0,  0, 1);
    push_instr(K_I,  1, 0,  0, 1);
    push_instr(K_LW, 0, 2,  0, 1);
    push_instr(K_SW, 0, 0,  0, 1);
    push_instr(K_B,  0, 0,  1, 1);
    push_instr(K_B,  0, 0,  0, 1);
    push_instr(K_LW, 14, 14, 0, 1);
    push_instr(K_SW, 0, 14, 0, 0);
    // start_i dropped during EXEC_R: the instruction still completes, then IDLE
    push(S_IDLE, 1, 0, 0, ropc());
    push(S_FETCH, 1, 1, 0, ropc());
    push(S_DECODE, 1, 0, 0, opc_of(K_R));
    push(S_EXEC_R, 0, 0, 0, opc_of(K_R));
    retire(S_WB_ALU, 0, 0, opc_of(K_R), 0);
    push(S_IDLE, 0, 1, 0, ropc());
    push(S_IDLE, 0, 1, 0, ropc());
    run_table("directed");

    // Random instruction mix
    for (int i = 0; i < 40; i++)
      push_instr(int'($urandom_range(4, 0)), int'($urandom_range(3, 0)),
                 int'($urandom_range(3, 0)), rbit(),
                 (i == 39) ? 1'b0 : ($urandom_range(3, 0) != 0));
    push(S_IDLE, 0, rbit(), rbit(), ropc());
    run_table("random");

    // Asynchronous reset in the middle of a fetch
    @(negedge clk);
    bus.start_i = 1; bus.mem_ready_i = 0;
    @(negedge clk); #1;
    check("midfetch state", 32'(bus.state_o),   32'(S_FETCH));
    check("midfetch req",   32'(bus.mem_req_o), 32'(1));
    #2 rst = 1;
    #1;
    check("async rst state",   32'(bus.state_o),   32'(S_IDLE));
    check("async rst outs",    32'(act_outs()),    32'(0));
    check("async rst retired", 32'(bus.retired_o), 32'(0));
    @(negedge clk);
    bus.start_i = 0; rst = 0;
    model_reset();
    for (int k = 0; k < 3; k++) push(S_IDLE, 0, rbit(), rbit(), ropc());
    run_table("post-reset");

    // Illegal opcode trap, sticky despite start_i
    push(S_IDLE, 1, 0, 0, ropc());
    push(S_FETCH, 1, 1, 0, ropc());
    push(S_DECODE, 1, 0, 0, 7'b1111111);
    f_ill = 1;
    for (int k = 0; k < 20; k++) push(S_TRAP, 1, rbit(), rbit(), ropc());
    run_table("illegal");

    // Fetch timeout trap after MEM_TIMEOUT wait cycles
    do_reset();
    push(S_IDLE, 1, 0, 0, ropc());
    for (int k = 0; k < MEM_TIMEOUT; k++) push(S_FETCH, 1, 0, rbit(), ropc());
    f_to = 1;
    for (int k = 0; k < 20; k++) push(S_TRAP, 1, rbit(), rbit(), ropc());
    run_table("timeout");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
